sync_multimode_counter: RTL and testbench

Parametrised successor to the team's 4-bit up/down counter. Adds a run-time modulus limit, a programmable step size, and three overflow modes: wrap, saturate and one-shot. It also provides registered boundary flags and a terminal-count pulse. It serves as the general-purpose event, timer and address counter in single-clock datapaths.

---
 rtl/counter_pkg.sv | 23 ++
 rtl/updown_step_calc.sv | 72 +++++++
 rtl/sync_multimode_counter.sv | 100 ++++++++++
 tb/tb_sync_multimode_counter.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// counter_pkg: shared types and encodings for sync_multimode_counter.
//   mode_e  - overflow behaviour selected by the 2-bit mode input
//   state_e - one-shot state machine states
package counter_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP     = 2'b00,
        MODE_SATURATE = 2'b01,
        MODE_ONESHOT  = 2'b10,
        MODE_RSVD     = 2'b11   // decoded as WRAP
    } mode_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_e;

    localparam logic [1:0] MODE_WRAP_ENC     = 2'b00;
    localparam logic [1:0] MODE_SATURATE_ENC = 2'b01;
    localparam logic [1:0] MODE_ONESHOT_ENC  = 2'b10;
    localparam logic [1:0] MODE_RSVD_ENC     = 2'b11;

endpackage

// File: rtl/updown_step_calc.sv
// updown_step_calc: combinational next-count computation for one enabled
// update of an in-range count (count <= limit).
//   count, step, limit, up, mode -> next_count, boundary_hit
//   boundary_hit: the update wrapped, landed on, or was clamped at the
//   terminal value (limit going up, 0 going down).
import counter_pkg::*;

module updown_step_calc #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) (
    input  logic [WIDTH-1:0]  count,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  limit,
    input  logic              up,
    input  logic [1:0]        mode,
    output logic [WIDTH-1:0]  next_count,
    output logic              boundary_hit
);

    // Two guard bits: count + M (down wrap) must not overflow.
    localparam int XW = WIDTH + 2;

    logic [XW-1:0] cnt_x, stp_x, lim_x, mod_x, stp_m, sum_x;
    mode_e         md;
    logic          is_wrap, is_sat;

    always_comb begin
        cnt_x        = XW'(count);
        stp_x        = XW'(step);
        lim_x        = XW'(limit);
        mod_x        = lim_x + XW'(1);
        stp_m        = stp_x % mod_x;      // only meaningful for WRAP
        sum_x        = cnt_x + stp_x;
        md           = mode_e'(mode);
        is_sat       = (md == MODE_SATURATE);
        is_wrap      = (md == MODE_WRAP) || (md == MODE_RSVD);
        next_count   = count;
        boundary_hit = 1'b0;

        if (stp_x == '0) begin
            // step 0 holds the count and never reports a boundary
            next_count   = count;
            boundary_hit = 1'b0;
        end else if (up) begin
            if (sum_x <= lim_x) begin
                next_count   = WIDTH'(sum_x);
                boundary_hit = (sum_x == lim_x);
            end else if (is_wrap) begin
                next_count   = WIDTH'((cnt_x + stp_m) % mod_x);
                boundary_hit = 1'b1;
            end else begin
                next_count   = limit;
                // A saturated counter already parked at limit does not
                // re-fire; a zero-width range fires on every update.
                boundary_hit = !is_sat || (cnt_x != lim_x) || (lim_x == '0);
            end
        end else begin
            if (cnt_x >= stp_x) begin
                next_count   = WIDTH'(cnt_x - stp_x);
                boundary_hit = (cnt_x == stp_x);
            end else if (is_wrap) begin
                next_count   = WIDTH'((cnt_x + mod_x - stp_m) % mod_x);
                boundary_hit = 1'b1;
            end else begin
                next_count   = '0;
                boundary_hit = !is_sat || (cnt_x != '0) || (lim_x == '0);
            end
        end
    end

endmodule

// File: rtl/sync_multimode_counter.sv
// sync_multimode_counter: up/down counter with run-time limit, step size
// and WRAP / SATURATE / ONESHOT overflow modes.
//   clk, rst (sync, active high)
//   enable, up, load, load_val, step, limit, mode : controls
//   count  : current count (0..limit)
//   at_max : count == limit, at_min : count == 0 (registered)
//   tc     : one-cycle terminal-count pulse
//   done   : one-shot has completed (cleared by load or rst)
import counter_pkg::*;

module sync_multimode_counter #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              up,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  limit,
    input  logic [1:0]        mode,
    output logic [WIDTH-1:0]  count,
    output logic              at_max,
    output logic              at_min,
    output logic              tc,
    output logic              done
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             at_max_q, at_max_d;
    logic             at_min_q, at_min_d;
    logic             tc_q, tc_d;
    state_e           state_q, state_d;

    logic [WIDTH-1:0] calc_next;
    logic             calc_hit;

    updown_step_calc #(
        .WIDTH  (WIDTH),
        .STEP_W (STEP_W)
    ) u_calc (
        .count        (count_q),
        .step         (step),
        .limit        (limit),
        .up           (up),
        .mode         (mode),
        .next_count   (calc_next),
        .boundary_hit (calc_hit)
    );

    always_comb begin
        count_d = count_q;
        state_d = state_q;
        tc_d    = 1'b0;

        if (load) begin
            count_d = (load_val > limit) ? limit : load_val;
            state_d = ST_RUN;
        end else if (enable && (state_q == ST_RUN)) begin
            if (count_q > limit) begin
                // limit was lowered under us: pull back into range silently
                count_d = limit;
            end else begin
                count_d = calc_next;
                tc_d    = calc_hit;
                if (calc_hit && (mode == MODE_ONESHOT_ENC))
                    state_d = ST_DONE;
            end
        end

        // Flags come from the value being registered so they align with count.
        at_max_d = (count_d == limit);
        at_min_d = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= '0;
            state_q  <= ST_RUN;
            tc_q     <= 1'b0;
            at_min_q <= 1'b1;
            at_max_q <= (limit == '0);
        end else begin
            count_q  <= count_d;
            state_q  <= state_d;
            tc_q     <= tc_d;
            at_min_q <= at_min_d;
            at_max_q <= at_max_d;
        end
    end

    assign count  = count_q;
    assign at_max = at_max_q;
    assign at_min = at_min_q;
    assign tc     = tc_q;
    assign done   = (state_q == ST_DONE);

endmodule

// File: tb/tb_sync_multimode_counter.sv
module tb_sync_multimode_counter;

    logic       clk;
    logic       rst, enable, up, load;
    logic [3:0] load_val, limit;
    logic [2:0] step;
    logic [1:0] mode;
    logic [3:0] count;
    logic       at_max, at_min, tc, done;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [3:0] cnt;
        logic       mx;
        logic       mn;
        logic       tc;
        logic       dn;
        string      nm;
    } exp_t;

    exp_t q[$];

    sync_multimode_counter #(.WIDTH(4), .STEP_W(3)) dut (
        .clk(clk), .rst(rst), .enable(enable), .up(up), .load(load),
        .load_val(load_val), .step(step), .limit(limit), .mode(mode),
        .count(count), .at_max(at_max), .at_min(at_min), .tc(tc), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs (at negedge) and queue the response expected
    // after the following rising edge.
    task automatic drv(input logic r, input logic ld, input logic en, input logic u,
                       input logic [3:0] lv, input logic [3:0] lim, input logic [2:0] st,
                       input logic [1:0] md, input logic [3:0] e_cnt, input logic e_mx,
                       input logic e_mn, input logic e_tc, input logic e_dn, input string nm);
        exp_t e;
        @(negedge clk);
        rst = r; load = ld; enable = en; up = u;
        load_val = lv; limit = lim; step = st; mode = md;
        e.cnt = e_cnt; e.mx = e_mx; e.mn = e_mn; e.tc = e_tc; e.dn = e_dn; e.nm = nm;
        q.push_back(e);
    endtask

    // Monitor: every rising edge presents a new output vector.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                n_tests++;
                if (count !== e.cnt || at_max !== e.mx || at_min !== e.mn ||
                    tc !== e.tc || done !== e.dn) begin
                    n_fail++;
                    $display("FAIL %s: got cnt=%0d max=%b min=%b tc=%b done=%b, want cnt=%0d max=%b min=%b tc=%b done=%b",
                             e.nm, count, at_max, at_min, tc, done,
                             e.cnt, e.mx, e.mn, e.tc, e.dn);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; load = 1'b0; enable = 1'b0; up = 1'b1;
        load_val = '0; limit = 4'd9; step = '0; mode = 2'b00;

        //   rst ld en up  lv     lim    st    md     cnt   mx mn tc dn
        // 1. reset
        drv(1, 0, 0, 1, 4'd0, 4'd9, 3'd0, 2'd0, 4'd0, 0, 1, 0, 0, "reset1");
        drv(1, 0, 0, 1, 4'd0, 4'd9, 3'd0, 2'd0, 4'd0, 0, 1, 0, 0, "reset2");
        drv(0, 0, 0, 1, 4'd0, 4'd9, 3'd0, 2'd0, 4'd0, 0, 1, 0, 0, "reset_rel");
        // 2. WRAP up, limit 9, step 3: 3, 6, 9 (tc), 12-10=2 (tc)
        drv(0, 0, 1, 1, 4'd0, 4'd9, 3'd3, 2'd0, 4'd3, 0, 0, 0, 0, "wrap_up3");
        drv(0, 0, 1, 1, 4'd0, 4'd9, 3'd3, 2'd0, 4'd6, 0, 0, 0, 0, "wrap_up6");
        drv(0, 0, 1, 1, 4'd0, 4'd9, 3'd3, 2'd0, 4'd9, 1, 0, 1, 0, "wrap_up9");
        drv(0, 0, 1, 1, 4'd0, 4'd9, 3'd3, 2'd0, 4'd2, 0, 0, 1, 0, "wrap_up_wrap");
        // 3. SATURATE down from 5, step 2: 3, 1, 0 (tc), 0
        drv(0, 1, 0, 0, 4'd5, 4'd9, 3'd2, 2'd1, 4'd5, 0, 0, 0, 0, "sat_load5");
        drv(0, 0, 1, 0, 4'd0, 4'd9, 3'd2, 2'd1, 4'd3, 0, 0, 0, 0, "sat_dn3");
        drv(0, 0, 1, 0, 4'd0, 4'd9, 3'd2, 2'd1, 4'd1, 0, 0, 0, 0, "sat_dn1");
        drv(0, 0, 1, 0, 4'd0, 4'd9, 3'd2, 2'd1, 4'd0, 0, 1, 1, 0, "sat_dn0");
        drv(0, 0, 1, 0, 4'd0, 4'd9, 3'd2, 2'd1, 4'd0, 0, 1, 0, 0, "sat_hold0");
        // 4. ONESHOT up, limit 7, step 3: 3, 6, 7 done; hold; load 2
        drv(0, 1, 0, 1, 4'd0, 4'd7, 3'd3, 2'd2, 4'd0, 0, 1, 0, 0, "os_load0");
        drv(0, 0, 1, 1, 4'd0, 4'd7, 3'd3, 2'd2, 4'd3, 0, 0, 0, 0, "os_up3");
        drv(0, 0, 1, 1, 4'd0, 4'd7, 3'd3, 2'd2, 4'd6, 0, 0, 0, 0, "os_up6");
        drv(0, 0, 1, 1, 4'd0, 4'd7, 3'd3, 2'd2, 4'd7, 1, 0, 1, 1, "os_done");
        drv(0, 0, 1, 1, 4'd0, 4'd7, 3'd3, 2'd2, 4'd7, 1, 0, 0, 1, "os_hold");
        drv(0, 1, 0, 1, 4'd2, 4'd7, 3'd3, 2'd2, 4'd2, 0, 0, 0, 0, "os_reload");
        // 5. load beats enable and is clamped; rst beats load
        drv(0, 1, 1, 1, 4'd12, 4'd10, 3'd1, 2'd0, 4'd10, 1, 0, 0, 0, "load_clamp");
        drv(1, 1, 1, 1, 4'd3, 4'd10, 3'd1, 2'd0, 4'd0, 0, 1, 0, 0, "rst_over_load");
        // 6. limit lowered under the count
        drv(0, 1, 0, 1, 4'd8, 4'd10, 3'd1, 2'd0, 4'd8, 0, 0, 0, 0, "lim_load8");
        drv(0, 0, 1, 1, 4'd0, 4'd5, 3'd1, 2'd0, 4'd5, 1, 0, 0, 0, "lim_pull_in");
        drv(0, 0, 0, 1, 4'd0, 4'd5, 3'd1, 2'd0, 4'd5, 1, 0, 0, 0, "lim_hold");
        // limit 0: WRAP pulses every enabled cycle (back-to-back)
        drv(0, 1, 0, 1, 4'd0, 4'd0, 3'd2, 2'd0, 4'd0, 1, 1, 0, 0, "lim0_load");
        drv(0, 0, 1, 1, 4'd0, 4'd0, 3'd2, 2'd0, 4'd0, 1, 1, 1, 0, "lim0_wrap_a");
        drv(0, 0, 1, 1, 4'd0, 4'd0, 3'd2, 2'd0, 4'd0, 1, 1, 1, 0, "lim0_wrap_b");
        // limit 0 ONESHOT: first enable finishes; DONE survives a mode change
        drv(0, 0, 1, 1, 4'd0, 4'd0, 3'd2, 2'd2, 4'd0, 1, 1, 1, 1, "lim0_os");
        drv(0, 0, 1, 1, 4'd0, 4'd0, 3'd2, 2'd2, 4'd0, 1, 1, 0, 1, "lim0_os_hold");
        drv(0, 0, 1, 1, 4'd0, 4'd0, 3'd2, 2'd0, 4'd0, 1, 1, 0, 1, "done_mode_chg");
        drv(0, 1, 0, 1, 4'd0, 4'd0, 3'd2, 2'd0, 4'd0, 1, 1, 0, 0, "done_clr");
        // step 0 holds even sitting on the terminal value
        drv(0, 1, 0, 1, 4'd9, 4'd9, 3'd0, 2'd0, 4'd9, 1, 0, 0, 0, "s0_load9");
        drv(0, 0, 1, 1, 4'd0, 4'd9, 3'd0, 2'd0, 4'd9, 1, 0, 0, 0, "s0_hold");
        // WRAP down: 1 + 10 - 3 = 8
        drv(0, 1, 0, 0, 4'd1, 4'd9, 3'd3, 2'd0, 4'd1, 0, 0, 0, 0, "wdn_load1");
        drv(0, 0, 1, 0, 4'd0, 4'd9, 3'd3, 2'd0, 4'd8, 0, 0, 1, 0, "wdn_wrap8");
        // down landing exactly on 0 pulses tc
        drv(0, 1, 0, 0, 4'd3, 4'd9, 3'd3, 2'd0, 4'd3, 0, 0, 0, 0, "land_load3");
        drv(0, 0, 1, 0, 4'd0, 4'd9, 3'd3, 2'd0, 4'd0, 0, 1, 1, 0, "land_zero");
        // step > M in WRAP: limit 2, M 3, 1 + (7 mod 3) = 2
        drv(0, 1, 0, 1, 4'd1, 4'd2, 3'd7, 2'd0, 4'd1, 0, 0, 0, 0, "big_load1");
        drv(0, 0, 1, 1, 4'd0, 4'd2, 3'd7, 2'd0, 4'd2, 1, 0, 1, 0, "big_step");
        // reserved mode behaves as WRAP: 8 + 3 - 10 = 1
        drv(0, 1, 0, 1, 4'd8, 4'd9, 3'd3, 2'd3, 4'd8, 0, 0, 0, 0, "rsv_load8");
        drv(0, 0, 1, 1, 4'd0, 4'd9, 3'd3, 2'd3, 4'd1, 0, 0, 1, 0, "rsv_wrap");

        @(negedge clk);
        enable = 1'b0; load = 1'b0;
        // bounded drain of the scoreboard
        for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d entries left, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
